// File: rtl/alu_pkg.sv
// Shared types for alu_mc: opcode encoding, flag bit positions, FSM states and a flag packer.
package alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD = 5'd0,
      OP_OR  = 5'd1,
      OP_ADC = 5'd2,
      OP_SBC = 5'd3,
      OP_AND = 5'd4,
      OP_SUB = 5'd5,
      OP_XOR = 5'd6,
      OP_DIV = 5'd21,
      OP_MUL = 5'd22
   } alu_op_t;

   typedef enum int unsigned {
      FLAG_Z = 0,
      FLAG_C = 1,
      FLAG_V = 2,
      FLAG_S = 3
   } flag_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } alu_state_t;

   function automatic logic [3:0] pack_flags(input logic s, input logic v,
                                             input logic c, input logic z);
      logic [3:0] f;
      f         = '0;
      f[FLAG_S] = s;
      f[FLAG_V] = v;
      f[FLAG_C] = c;
      f[FLAG_Z] = z;
      return f;
   endfunction

endpackage

// File: rtl/alu_mc_div.sv
// Restoring shift-subtract divider, one quotient bit per cycle. The load cycle
// already performs the first step; the parent FSM counts the remaining steps.
module alu_mc_div
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH/2-1:0] divisor,
   output logic [WIDTH/2-1:0] remainder,
   output logic [WIDTH/2-1:0] quotient
);

   localparam int H = WIDTH / 2;

   logic [H-1:0] dsr;
   logic [H-1:0] rem_in;
   logic [H-1:0] quo_in;
   logic [H-1:0] dsr_in;
   logic [H:0]   trial;
   logic [H:0]   diff;

   // Partial remainder stays below the divisor, so trial fits in H+1 bits and
   // diff[H] is the borrow of the trial subtraction.
   always_comb begin
      rem_in = load ? dividend[WIDTH-1:H] : remainder;
      quo_in = load ? dividend[H-1:0]     : quotient;
      dsr_in = load ? divisor             : dsr;
      trial  = {rem_in, quo_in[H-1]};
      diff   = trial - {1'b0, dsr_in};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dsr       <= '0;
         remainder <= '0;
         quotient  <= '0;
      end else begin
         if (load)
            dsr <= divisor;
         if (!diff[H]) begin
            remainder <= diff[H-1:0];
            quotient  <= {quo_in[H-2:0], 1'b1};
         end else begin
            remainder <= trial[H-1:0];
            quotient  <= {quo_in[H-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with single-cycle logic/arith, shift-add MUL and an
// iterative DIV. Define ALU_MC_DIV_EN to build the divider; otherwise DIV answers as divide-by-zero.
//
// state   | meaning
// ST_IDLE | accepting start; single-cycle ops and DIV exceptions retire here
// ST_MUL  | shift-add iterations, one multiplier bit per cycle
// ST_DIV  | restoring-divide iterations in alu_mc_div
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             flush,
   input  logic [4:0]       alu_op,
   input  logic             size,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] R,
   output logic [3:0]       flags
);

   localparam int H  = WIDTH / 2;
   localparam int CW = $clog2(H);
   localparam logic [CW-1:0] LAST = CW'(H - 1);

   alu_state_t     state;
   logic [CW-1:0]  cnt;
   logic [WIDTH-1:0] mul_acc;
   logic [WIDTH-1:0] mul_mcand;
   logic [H-1:0]     mul_mplier;
   logic [WIDTH-1:0] mul_next;

   logic [WIDTH:0]   add_full, sub_full;
   logic [H:0]       add_half, sub_half;
   logic             cin_add, cin_sub;
   logic [WIDTH-1:0] logic_w;
   logic [WIDTH-1:0] sc_r;
   logic [3:0]       sc_flags;
   logic             sc_c, sc_v, sc_z, sc_ok, is_add, is_sub, is_logic;
   logic             a_m, b_m, r_m;

   // Subtraction is A + ~B + cin; carry-in acts as not-borrow for SBC.
   always_comb begin
      cin_add  = (alu_op == OP_ADC) ? C : 1'b0;
      cin_sub  = (alu_op == OP_SBC) ? C : 1'b1;
      add_full = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin_add};
      sub_full = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, cin_sub};
      add_half = {1'b0, A[H-1:0]} + {1'b0, B[H-1:0]} + {{H{1'b0}}, cin_add};
      sub_half = {1'b0, A[H-1:0]} + {1'b0, ~B[H-1:0]} + {{H{1'b0}}, cin_sub};
   end

   always_comb begin
      sc_r     = '0;
      sc_c     = 1'b0;
      sc_ok    = 1'b1;
      is_add   = 1'b0;
      is_sub   = 1'b0;
      is_logic = 1'b0;
      logic_w  = '0;
      case (alu_op)
         OP_ADD, OP_ADC: begin
            is_add = 1'b1;
            sc_r   = size ? add_full[WIDTH-1:0] : {A[WIDTH-1:H], add_half[H-1:0]};
            sc_c   = size ? add_full[WIDTH] : add_half[H];
         end
         OP_SUB, OP_SBC: begin
            is_sub = 1'b1;
            sc_r   = size ? sub_full[WIDTH-1:0] : {A[WIDTH-1:H], sub_half[H-1:0]};
            sc_c   = ~(size ? sub_full[WIDTH] : sub_half[H]);
         end
         OP_AND: begin is_logic = 1'b1; logic_w = A & B; end
         OP_OR:  begin is_logic = 1'b1; logic_w = A | B; end
         OP_XOR: begin is_logic = 1'b1; logic_w = A ^ B; end
         default: sc_ok = 1'b0;
      endcase
      if (is_logic)
         sc_r = size ? logic_w : {A[WIDTH-1:H], logic_w[H-1:0]};
      a_m  = size ? A[WIDTH-1] : A[H-1];
      b_m  = size ? B[WIDTH-1] : B[H-1];
      r_m  = size ? sc_r[WIDTH-1] : sc_r[H-1];
      sc_z = size ? (sc_r == '0) : (sc_r[H-1:0] == '0);
      sc_v = (is_add && (a_m == b_m) && (r_m != a_m)) ||
             (is_sub && (a_m != b_m) && (r_m != a_m));
      sc_flags = sc_ok ? pack_flags(r_m, sc_v, sc_c, sc_z) : 4'b0000;
   end

   assign mul_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
   assign busy     = (state != ST_IDLE);

`ifdef ALU_MC_DIV_EN
   logic         div_zero, div_ovf, div_load;
   logic [H-1:0] div_rem, div_quo;

   assign div_zero = (B[H-1:0] == '0);
   assign div_ovf  = (A[WIDTH-1:H] >= B[H-1:0]);
   assign div_load = (state == ST_IDLE) && start && (alu_op == OP_DIV) && !div_zero && !div_ovf;

   alu_mc_div #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (div_load),
      .dividend  (A),
      .divisor   (B[H-1:0]),
      .remainder (div_rem),
      .quotient  (div_quo)
   );
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         R          <= '0;
         flags      <= '0;
         done       <= 1'b0;
         mul_acc    <= '0;
         mul_mcand  <= '0;
         mul_mplier <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (alu_op == OP_MUL) begin
                     state      <= ST_MUL;
                     cnt        <= '0;
                     mul_acc    <= '0;
                     mul_mcand  <= {{H{1'b0}}, A[H-1:0]};
                     mul_mplier <= B[H-1:0];
`ifdef ALU_MC_DIV_EN
                  end else if (div_load) begin
                     state <= ST_DIV;
                     cnt   <= '0;
                  end else if (alu_op == OP_DIV) begin
                     R     <= A;
                     flags <= pack_flags(div_zero, 1'b1, 1'b0, 1'b0);
                     done  <= 1'b1;
`else
                  end else if (alu_op == OP_DIV) begin
                     R     <= A;
                     flags <= pack_flags(1'b1, 1'b1, 1'b0, 1'b0);
                     done  <= 1'b1;
`endif
                  end else begin
                     R     <= sc_r;
                     flags <= sc_flags;
                     done  <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               if (flush) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  mul_acc    <= mul_next;
                  mul_mcand  <= mul_mcand << 1;
                  mul_mplier <= mul_mplier >> 1;
                  cnt        <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                     R     <= mul_next;
                     flags <= pack_flags(mul_next[WIDTH-1], 1'b0, 1'b0, mul_next == '0);
                     done  <= 1'b1;
                  end
               end
            end
`ifdef ALU_MC_DIV_EN
            ST_DIV: begin
               if (flush) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                     R     <= {div_rem, div_quo};
                     flags <= pack_flags(div_quo[H-1], 1'b0, 1'b0, div_quo == '0);
                     done  <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=16; DIV expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic        size = 1'b0;
   logic        cin = 1'b0;
   logic [4:0]  alu_op = 5'd0;
   logic [15:0] op_a = '0;
   logic [15:0] op_b = '0;
   logic        busy, done;
   logic [15:0] R;
   logic [3:0]  flags;

   int n_checks = 0;
   int n_errors = 0;
   int lat, nbusy, ndone;

   alu_mc #(.WIDTH(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .flush   (flush),
      .alu_op  (alu_op),
      .size    (size),
      .A       (op_a),
      .B       (op_b),
      .C       (cin),
      .busy    (busy),
      .done    (done),
      .R       (R),
      .flags   (flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one start, then samples #1 after each edge until done (bounded).
   task automatic run_op(input logic [4:0] op, input logic sz, input logic [15:0] a,
                         input logic [15:0] b, input logic c, input bit poke, input bit fl);
      alu_op = op; size = sz; op_a = a; op_b = b; cin = c; flush = fl; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0; op_a = ~a; op_b = ~b; cin = ~c;
      lat = 1;
      nbusy = busy ? 1 : 0;
      while (!done && lat < 40) begin
         start = poke && (lat == 2);
         if (start) alu_op = OP_ADD;
         @(posedge clk); #1;
         lat++;
         if (busy) nbusy++;
      end
      start = 1'b0;
   endtask

   task automatic expect_op(input string tag, input logic [15:0] r_exp,
                            input logic [3:0] f_exp, input int lat_exp);
      check({tag, "_R"}, R, r_exp);
      check({tag, "_flags"}, flags, f_exp);
      check({tag, "_lat"}, lat, lat_exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("rst_R", R, 16'h0000);
      check("rst_flags", flags, 4'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      check("idle_done", done, 1'b0);

      run_op(OP_ADD, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      expect_op("add_ovf", 16'h8000, 4'hC, 1);
      @(posedge clk); #1;
      check("add_done_pulse", done, 1'b0);
      check("add_R_hold", R, 16'h8000);

      run_op(OP_SBC, 1'b0, 16'hAB00, 16'h0001, 1'b1, 1'b0, 1'b0);
      expect_op("sbc_byte", 16'hABFF, 4'hA, 1);
      run_op(OP_SUB, 1'b1, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0);
      expect_op("sub_neg", 16'hFFFE, 4'hA, 1);
      run_op(OP_AND, 1'b0, 16'hF0F0, 16'h0F0F, 1'b0, 1'b0, 1'b0);
      expect_op("and_byte_z", 16'hF000, 4'h1, 1);
      run_op(OP_OR, 1'b0, 16'h1200, 16'h0080, 1'b0, 1'b0, 1'b0);
      expect_op("or_byte_s", 16'h1280, 4'h8, 1);
      run_op(OP_ADD, 1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
      expect_op("add_byte_carry", 16'h0000, 4'h3, 1);
      run_op(OP_ADC, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
      expect_op("adc_wrap", 16'h0000, 4'h3, 1);
      run_op(OP_XOR, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      expect_op("xor_flush_idle", 16'hFFFE, 4'h8, 1);
      run_op(5'd7, 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b0);
      expect_op("illegal", 16'h0000, 4'h0, 1);

      run_op(OP_MUL, 1'b0, 16'h00FF, 16'h00FF, 1'b0, 1'b1, 1'b0);
      expect_op("mul_ff", 16'hFE01, 4'h8, 9);
      check("mul_busy_cycles", nbusy, 8);
      check("mul_busy_done", busy, 1'b0);
      run_op(OP_MUL, 1'b1, 16'hAA12, 16'h5534, 1'b0, 1'b0, 1'b0);
      expect_op("mul_b2b", 16'h03A8, 4'h0, 9);

      alu_op = OP_MUL; op_a = 16'h0003; op_b = 16'h0005; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("flush_busy_pre", busy, 1'b1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy_post", busy, 1'b0);
      ndone = 0;
      repeat (12) begin
         if (done) ndone++;
         @(posedge clk); #1;
      end
      check("flush_no_done", ndone, 0);
      check("flush_R", R, 16'h03A8);
      check("flush_flags", flags, 4'h0);

`ifdef ALU_MC_DIV_EN
      run_op(OP_DIV, 1'b1, 16'h1234, 16'h0056, 1'b0, 1'b0, 1'b0);
      expect_op("div", 16'h1036, 4'h0, 9);
      check("div_busy_cycles", nbusy, 8);
      run_op(OP_DIV, 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
      expect_op("div_zero", 16'h1234, 4'hC, 1);
      run_op(OP_DIV, 1'b1, 16'h5600, 16'h0056, 1'b0, 1'b0, 1'b0);
      expect_op("div_ovf", 16'h5600, 4'h4, 1);
`else
      run_op(OP_DIV, 1'b1, 16'h1234, 16'h0056, 1'b0, 1'b0, 1'b0);
      expect_op("div_off", 16'h1234, 4'hC, 1);
      run_op(OP_DIV, 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
      expect_op("div_zero", 16'h1234, 4'hC, 1);
      run_op(OP_DIV, 1'b1, 16'h5600, 16'h0056, 1'b0, 1'b0, 1'b0);
      expect_op("div_ovf_off", 16'h5600, 4'hC, 1);
`endif

`ifdef ALU_MC_DIV_EN
      alu_op = OP_DIV;
`else
      alu_op = OP_MUL;
`endif
      op_a = 16'h1234; op_b = 16'h0056; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #4;
      check("midop_busy", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      check("arst_R", R, 16'h0000);
      check("arst_flags", flags, 4'h0);
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      #2 reset_n = 1'b1;
      ndone = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("arst_no_done", ndone, 0);
      run_op(OP_ADD, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
      expect_op("post_rst_add", 16'h0002, 4'h0, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
